// File: rtl/temp_regulator.sv
// Water temperature regulator: ramps a simulated temperature to a latched target, then holds it with hysteresis.
// Optional heating timeout (HEAT -> FAULT) is built only when TEMP_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | heater off, cooling toward AMBIENT, waiting for start
// S_HEAT  | heater on, ramping toward tgt
// S_HOLD  | regulating between tgt_lo and tgt, temp_ready when >= tgt_lo
// S_FAULT | heating timed out; sticky until start drops
module temp_regulator #(
  parameter int TEMP_W      = 8,
  parameter int AMBIENT     = 20,
  parameter int MAX_TEMP    = 95,
  parameter int HYST        = 2,
  parameter int RAMP_DIV    = 4,
  parameter int COOL_DIV    = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [TEMP_W-1:0] target_temp,
  output logic              heater_on,
  output logic              temp_ready,
  output logic              fault,
  output logic              busy,
  output logic [TEMP_W-1:0] cur_temp
);

  typedef enum logic [1:0] {S_IDLE, S_HEAT, S_HOLD, S_FAULT} state_t;

  localparam int PRE_MAX = (RAMP_DIV > COOL_DIV) ? RAMP_DIV : COOL_DIV;
  localparam int PRE_W   = (PRE_MAX > 1) ? $clog2(PRE_MAX) : 1;

  localparam logic [PRE_W-1:0]  RAMP_LAST = PRE_W'(RAMP_DIV - 1);
  localparam logic [PRE_W-1:0]  COOL_LAST = PRE_W'(COOL_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
  localparam logic [TEMP_W-1:0] AMB_T     = TEMP_W'(AMBIENT);
  localparam logic [TEMP_W-1:0] MAX_T     = TEMP_W'(MAX_TEMP);
  localparam logic [TEMP_W-1:0] HYST_T    = TEMP_W'(HYST);
  localparam logic [TEMP_W-1:0] TEMP_ONE  = TEMP_W'(1);

  state_t            state, state_nxt;
  logic [TEMP_W-1:0] tgt, tgt_nxt;
  logic [TEMP_W-1:0] temp_nxt;
  logic [TEMP_W-1:0] tgt_lo, tgt_req;
  logic [PRE_W-1:0]  presc_cnt, presc_nxt;
  logic              step_due;
  logic              heater_nxt, ready_nxt, fault_nxt, busy_nxt;
  logic              timeout_hit;

`ifdef TEMP_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [TMO_W-1:0] tmo_cnt;

  // Any cycle outside HEAT zeroes the count, so it starts at 0 on HEAT entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state != S_HEAT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

  assign timeout_hit = (tmo_cnt == TMO_LAST);
`else
  // No timeout hardware: TIMEOUT_CYC is inert and FAULT cannot be reached.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  assign tgt_lo   = (tgt > HYST_T) ? (tgt - HYST_T) : '0;
  assign tgt_req  = (target_temp > MAX_T) ? MAX_T : target_temp;
  assign step_due = (presc_cnt >= (heater_on ? RAMP_LAST : COOL_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cur_temp   <= AMB_T;
      tgt        <= '0;
      presc_cnt  <= '0;
      heater_on  <= 1'b0;
      temp_ready <= 1'b0;
      fault      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_temp   <= temp_nxt;
      tgt        <= tgt_nxt;
      presc_cnt  <= presc_nxt;
      heater_on  <= heater_nxt;
      temp_ready <= ready_nxt;
      fault      <= fault_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tgt_nxt    = tgt;
    heater_nxt = heater_on;
    ready_nxt  = temp_ready;
    fault_nxt  = fault;

    case (state)
      S_IDLE: begin
        heater_nxt = 1'b0;
        ready_nxt  = 1'b0;
        fault_nxt  = 1'b0;
        if (start) begin
          tgt_nxt = tgt_req;
          if (cur_temp >= tgt_req) begin
            state_nxt = S_HOLD;
            ready_nxt = 1'b1;
          end else begin
            state_nxt  = S_HEAT;
            heater_nxt = 1'b1;
          end
        end
      end
      S_HEAT: begin
        if (!start) begin
          state_nxt  = S_IDLE;
          heater_nxt = 1'b0;
          ready_nxt  = 1'b0;
          fault_nxt  = 1'b0;
        end else if (cur_temp >= tgt) begin
          state_nxt  = S_HOLD;
          heater_nxt = 1'b0;
          ready_nxt  = 1'b1;
        end else if (timeout_hit) begin
          state_nxt  = S_FAULT;
          heater_nxt = 1'b0;
          ready_nxt  = 1'b0;
          fault_nxt  = 1'b1;
        end
      end
      S_HOLD: begin
        if (!start) begin
          state_nxt  = S_IDLE;
          heater_nxt = 1'b0;
          ready_nxt  = 1'b0;
          fault_nxt  = 1'b0;
        end else begin
          if (cur_temp < tgt_lo) begin
            heater_nxt = 1'b1;
          end else if (cur_temp >= tgt) begin
            heater_nxt = 1'b0;
          end
          ready_nxt = (cur_temp >= tgt_lo);
        end
      end
      S_FAULT: begin
        heater_nxt = 1'b0;
        ready_nxt  = 1'b0;
        if (!start) begin
          state_nxt = S_IDLE;
          fault_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        heater_nxt = 1'b0;
        ready_nxt  = 1'b0;
        fault_nxt  = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);

    // A due step still lands on a state-change edge; only the count restarts.
    temp_nxt = cur_temp;
    if (step_due) begin
      if (heater_on) begin
        if (cur_temp < MAX_T) temp_nxt = cur_temp + TEMP_ONE;
      end else begin
        if (cur_temp > AMB_T) temp_nxt = cur_temp - TEMP_ONE;
      end
    end

    if (state_nxt != state || step_due) begin
      presc_nxt = '0;
    end else begin
      presc_nxt = presc_cnt + PRE_ONE;
    end
  end

endmodule

// File: tb/tb_temp_regulator.sv
// Bench for temp_regulator: cycle model of the regulation rules plus hand-computed pins.
// Build with TEMP_TIMEOUT_EN defined to exercise the timeout with TIMEOUT_CYC=100.
module tb_temp_regulator;

  localparam int TEMP_W = 8;
  localparam int AMB    = 20;
  localparam int MAXT   = 95;
  localparam int HYST   = 2;
  localparam int RDIV   = 4;
  localparam int CDIV   = 16;
`ifdef TEMP_TIMEOUT_EN
  localparam int TMO    = 100;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 1024;
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_HEAT  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_FAULT = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [TEMP_W-1:0] target_temp;
  logic              heater_on;
  logic              temp_ready;
  logic              fault;
  logic              busy;
  logic [TEMP_W-1:0] cur_temp;

  always #5 clk = ~clk;

  temp_regulator #(
    .TEMP_W(TEMP_W), .AMBIENT(AMB), .MAX_TEMP(MAXT), .HYST(HYST),
    .RAMP_DIV(RDIV), .COOL_DIV(CDIV), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .target_temp(target_temp),
    .heater_on(heater_on), .temp_ready(temp_ready), .fault(fault),
    .busy(busy), .cur_temp(cur_temp)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int e      = 0;

  // Model: mode, temperature, target, cycles since last step, completed HEAT cycles.
  int m_mode = M_IDLE;
  int m_temp = AMB;
  int m_tgt  = 0;
  int m_tick = 0;
  int m_hc   = 0;
  bit m_heat = 1'b0;
  bit m_ready = 1'b0;
  bit m_fault = 1'b0;

  task automatic model_go_idle();
    m_mode  = M_IDLE;
    m_heat  = 1'b0;
    m_ready = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic model_edge();
    int  old_mode = m_mode;
    int  nt       = m_temp;
    int  lo       = (m_tgt > HYST) ? m_tgt - HYST : 0;
    int  req      = (int'(target_temp) > MAXT) ? MAXT : int'(target_temp);
    bit  stepped  = 1'b0;
    if (m_tick >= (m_heat ? RDIV : CDIV) - 1) begin
      stepped = 1'b1;
      if (m_heat) nt = (m_temp + 1 > MAXT) ? MAXT : m_temp + 1;
      else        nt = (m_temp - 1 < AMB)  ? AMB  : m_temp - 1;
    end
    if (old_mode == M_IDLE) begin
      model_go_idle();
      if (start) begin
        m_tgt = req;
        if (m_temp >= req) begin
          m_mode = M_HOLD; m_ready = 1'b1;
        end else begin
          m_mode = M_HEAT; m_heat = 1'b1; m_hc = 0;
        end
      end
    end else if (!start) begin
      model_go_idle();
    end else if (old_mode == M_HEAT) begin
      m_hc++;
      if (m_temp >= m_tgt) begin
        m_mode = M_HOLD; m_heat = 1'b0; m_ready = 1'b1;
      end else if (TMO_EN && m_hc >= TMO) begin
        m_mode = M_FAULT; m_heat = 1'b0; m_ready = 1'b0; m_fault = 1'b1;
      end
    end else if (old_mode == M_HOLD) begin
      if (m_temp < lo)          m_heat = 1'b1;
      else if (m_temp >= m_tgt) m_heat = 1'b0;
      m_ready = (m_temp >= lo);
    end
    m_tick = (m_mode != old_mode || stepped) ? 0 : m_tick + 1;
    m_temp = nt;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_go_idle();
      m_temp = AMB; m_tgt = 0; m_tick = 0; m_hc = 0;
    end else begin
      model_edge();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (heater_on !== m_heat || temp_ready !== m_ready || fault !== m_fault ||
          busy !== (m_mode != M_IDLE) || cur_temp !== TEMP_W'(m_temp)) begin
        errors++;
        $display("FAIL model t=%0t got heat=%0b rdy=%0b flt=%0b busy=%0b temp=%0d want heat=%0b rdy=%0b flt=%0b busy=%0b temp=%0d",
                 $time, heater_on, temp_ready, fault, busy, cur_temp,
                 m_heat, m_ready, m_fault, (m_mode != M_IDLE), m_temp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s e=%0d got %0d want %0d", name, e, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  int  max_t;
  bit  heat_seen;

  initial begin
    reset_n = 1'b0; start = 1'b0; target_temp = '0;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("rst_temp", int'(cur_temp), 20);
    chk("rst_busy", int'(busy), 0);
    chk("rst_heat", int'(heater_on), 0);
    chk("rst_rdy", int'(temp_ready), 0);
    chk("rst_flt", int'(fault), 0);
    #3 reset_n = 1'b1;
    run(3);

    // Heat-up to 30, retarget to 50 mid-HEAT is ignored
    start = 1'b1; target_temp = 8'd30; e = 0;
    run(1);
    chk("heat_busy", int'(busy), 1);
    chk("heat_on", int'(heater_on), 1);
    chk("heat_t1", int'(cur_temp), 20);
    run(9);
    target_temp = 8'd50;
    run(30);
    chk("heat_t40", int'(cur_temp), 29);
    run(1);
    chk("heat_t41", int'(cur_temp), 30);
    chk("heat_rdy41", int'(temp_ready), 0);
    chk("heat_on41", int'(heater_on), 1);
    run(1);
    chk("hold_rdy42", int'(temp_ready), 1);
    chk("hold_heat42", int'(heater_on), 0);
    chk("hold_busy42", int'(busy), 1);

    // Hysteresis
    run(16);
    chk("hyst_t58", int'(cur_temp), 29);
    run(32);
    chk("hyst_t90", int'(cur_temp), 27);
    chk("hyst_heat90", int'(heater_on), 0);
    chk("hyst_rdy90", int'(temp_ready), 1);
    run(1);
    chk("hyst_heat91", int'(heater_on), 1);
    chk("hyst_rdy91", int'(temp_ready), 0);
    run(4);
    chk("hyst_rdy95", int'(temp_ready), 1);
    chk("hyst_t95", int'(cur_temp), 28);
    run(7);
    chk("hyst_t102", int'(cur_temp), 30);
    chk("hyst_heat102", int'(heater_on), 1);
    run(1);
    chk("hyst_heat103", int'(heater_on), 0);

    // Drop start from HOLD, cool to the floor
    start = 1'b0;
    run(1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_rdy", int'(temp_ready), 0);
    run(250);
    chk("idle_floor", int'(cur_temp), 20);

    // Clamp 200 -> 95
    start = 1'b1; target_temp = 8'd200; e = 0; max_t = 0;
    repeat (320) begin
      run(1);
      if (int'(cur_temp) > max_t) max_t = int'(cur_temp);
`ifndef TEMP_TIMEOUT_EN
      if (e == 302) begin
        chk("clamp_t302", int'(cur_temp), 95);
        chk("clamp_rdy302", int'(temp_ready), 1);
      end
`endif
    end
`ifndef TEMP_TIMEOUT_EN
    chk("clamp_max", max_t, 95);
`endif
    start = 1'b0;
    run(1300);
    chk("cool_floor", int'(cur_temp), 20);

    // Target below ambient: straight to HOLD, heater never on
    start = 1'b1; target_temp = 8'd15;
    run(1);
    chk("low_busy", int'(busy), 1);
    chk("low_rdy", int'(temp_ready), 1);
    heat_seen = 1'b0;
    repeat (60) begin
      run(1);
      heat_seen |= heater_on;
    end
    chk("low_noheat", int'(heat_seen), 0);

    // Abort mid-HEAT
    start = 1'b0;
    run(1);
    start = 1'b1; target_temp = 8'd40; e = 0;
    run(18);
    start = 1'b0;
    run(1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_heat", int'(heater_on), 0);
    chk("abort_t", int'(cur_temp), 24);
    run(100);
    chk("abort_floor", int'(cur_temp), 20);

    // Timeout window: 100 cycles of HEAT toward 60
    start = 1'b1; target_temp = 8'd60; e = 0;
    run(100);
    chk("tmo_t100", int'(cur_temp), 44);
    chk("tmo_heat100", int'(heater_on), 1);
    chk("tmo_flt100", int'(fault), 0);
    run(1);
    chk("tmo_t101", int'(cur_temp), 45);
`ifdef TEMP_TIMEOUT_EN
    chk("tmo_flt101", int'(fault), 1);
    chk("tmo_heat101", int'(heater_on), 0);
    chk("tmo_rdy101", int'(temp_ready), 0);
    run(20);
    chk("tmo_sticky", int'(fault), 1);
`else
    chk("notmo_flt101", int'(fault), 0);
    chk("notmo_heat101", int'(heater_on), 1);
`endif
    start = 1'b0;
    run(1);
    chk("tmo_clr_flt", int'(fault), 0);
    chk("tmo_clr_busy", int'(busy), 0);

    // Async reset mid-HOLD
    start = 1'b1; target_temp = 8'd25;
    run(10);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_rdy", int'(temp_ready), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_temp", int'(cur_temp), 20);
    chk("arst_busy", int'(busy), 0);
    chk("arst_rdy", int'(temp_ready), 0);
    chk("arst_heat", int'(heater_on), 0);
    start = 1'b0;
    run(2);
    #3 reset_n = 1'b1;
    run(5);
    chk("post_rst_busy", int'(busy), 0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

endmodule
